// File: rtl/mc_arb_pkg.sv
// Shared constants for the mc_mem_arbiter memory-port arbiter.
package mc_arb_pkg;

  localparam logic [1:0] REQ_INST = 2'd0;
  localparam logic [1:0] REQ_DATA = 2'd1;
  localparam logic [1:0] REQ_IO   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/mc_arb_rr_sel.sv
// Combinational 3-way picker: round-robin after the last winner, or fixed data > inst > io.
module mc_arb_rr_sel
  import mc_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] last,
  input  logic       mode,
  output logic [2:0] grant
);

  always_comb begin
    grant = '0;
    if (mode) begin
      if      (req[REQ_DATA]) grant[REQ_DATA] = 1'b1;
      else if (req[REQ_INST]) grant[REQ_INST] = 1'b1;
      else if (req[REQ_IO])   grant[REQ_IO]   = 1'b1;
    end else if (last[REQ_DATA]) begin
      if      (req[REQ_IO])   grant[REQ_IO]   = 1'b1;
      else if (req[REQ_INST]) grant[REQ_INST] = 1'b1;
      else if (req[REQ_DATA]) grant[REQ_DATA] = 1'b1;
    end else if (last[REQ_IO]) begin
      if      (req[REQ_INST]) grant[REQ_INST] = 1'b1;
      else if (req[REQ_DATA]) grant[REQ_DATA] = 1'b1;
      else if (req[REQ_IO])   grant[REQ_IO]   = 1'b1;
    end else begin
      // last == inst (also the reset value): search starts at data
      if      (req[REQ_DATA]) grant[REQ_DATA] = 1'b1;
      else if (req[REQ_IO])   grant[REQ_IO]   = 1'b1;
      else if (req[REQ_INST]) grant[REQ_INST] = 1'b1;
    end
  end

endmodule

// File: rtl/mc_mem_arbiter.sv
// Three-requester arbiter for the shared stb/ack memory port, one transaction at a time.
// Optional BUSY watchdog enabled by defining MC_ARB_TIMEOUT_EN.
module mc_mem_arbiter
  import mc_arb_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 16,
  parameter int unsigned PRIO_MODE   = 0,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          cpu_inst_stb_i,
  input  logic [AW-1:0] cpu_inst_addr_i,
  output logic [DW-1:0] cpu_inst_data_o,
  output logic          cpu_inst_ack_o,
  input  logic          cpu_data_stb_i,
  input  logic          cpu_data_we_i,
  input  logic [AW-1:0] cpu_data_addr_i,
  input  logic [DW-1:0] cpu_data_data_i,
  output logic [DW-1:0] cpu_data_data_o,
  output logic          cpu_data_ack_o,
  input  logic          io_stb_i,
  input  logic          io_we_i,
  input  logic [AW-1:0] io_addr_i,
  input  logic [DW-1:0] io_data_i,
  output logic [DW-1:0] io_data_o,
  output logic          io_ack_o,
  output logic          mem_stb_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  input  logic [DW-1:0] mem_data_i,
  input  logic          mem_ack_i,
  output logic [2:0]    grant_o,
  output logic          arb_err_o
);

  arb_state_t    r_state, w_next;
  logic [2:0]    r_grant, r_last, w_pick, w_req;
  logic [AW-1:0] r_addr, w_sel_addr;
  logic          r_we, w_sel_we;
  logic [DW-1:0] r_wdata, w_sel_wdata, w_rd_val;
  logic [DW-1:0] r_inst_rd, r_data_rd, r_io_rd;
  logic          w_tmo_hit, w_done, w_resp;

  assign w_req = {io_stb_i, cpu_data_stb_i, cpu_inst_stb_i};

  mc_arb_rr_sel u_sel (
    .req   (w_req),
    .last  (r_last),
    .mode  (PRIO_MODE != 0),
    .grant (w_pick)
  );

`ifdef MC_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tmo;
  logic          r_err;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_BUSY) r_tmo <= r_tmo + 1'b1;
      else                    r_tmo <= '0;
      if (w_done)                  r_err <= w_tmo_hit;
      else if (r_state == ST_RESP) r_err <= 1'b0;
    end
  end

  // a real ack in the expiry cycle wins, so the hit requires !mem_ack_i
  assign w_tmo_hit = (r_state == ST_BUSY) && !mem_ack_i && (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign arb_err_o = w_resp && r_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC != 0);
  assign w_tmo_hit    = 1'b0;
  assign arb_err_o    = 1'b0;
`endif

  assign w_done = (r_state == ST_BUSY) && (mem_ack_i || w_tmo_hit);
  assign w_resp = (r_state == ST_RESP);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (|w_req) w_next = ST_BUSY;
      ST_BUSY: if (w_done) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sel_addr  = cpu_inst_addr_i;
    w_sel_we    = 1'b0;
    w_sel_wdata = '0;
    if (w_pick[REQ_DATA]) begin
      w_sel_addr  = cpu_data_addr_i;
      w_sel_we    = cpu_data_we_i;
      w_sel_wdata = cpu_data_data_i;
    end else if (w_pick[REQ_IO]) begin
      w_sel_addr  = io_addr_i;
      w_sel_we    = io_we_i;
      w_sel_wdata = io_data_i;
    end
  end

  always_comb begin
    w_rd_val = '0;
    if (!mem_ack_i)  w_rd_val = DW'(TIMEOUT_DATA);
    else if (!r_we)  w_rd_val = mem_data_i;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_grant   <= '0;
      r_last    <= 3'b001;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_inst_rd <= '0;
      r_data_rd <= '0;
      r_io_rd   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (|w_req) begin
          r_grant <= w_pick;
          r_addr  <= w_sel_addr;
          r_we    <= w_sel_we;
          r_wdata <= w_sel_wdata;
        end
        ST_BUSY: if (w_done) begin
          if (r_grant[REQ_INST]) r_inst_rd <= w_rd_val;
          if (r_grant[REQ_DATA]) r_data_rd <= w_rd_val;
          if (r_grant[REQ_IO])   r_io_rd   <= w_rd_val;
        end
        ST_RESP: begin
          r_last  <= r_grant;
          r_grant <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mem_stb_o       = (r_state == ST_BUSY);
  assign mem_we_o        = r_we;
  assign mem_addr_o      = r_addr;
  assign mem_data_o      = r_wdata;
  assign grant_o         = r_grant;
  assign cpu_inst_ack_o  = w_resp && r_grant[REQ_INST];
  assign cpu_data_ack_o  = w_resp && r_grant[REQ_DATA];
  assign io_ack_o        = w_resp && r_grant[REQ_IO];
  assign cpu_inst_data_o = r_inst_rd;
  assign cpu_data_data_o = r_data_rd;
  assign io_data_o       = r_io_rd;

endmodule

// File: tb/tb_mc_mem_arbiter.sv
// Directed bench for mc_mem_arbiter: one round-robin and one fixed-priority instance share stimulus.
module tb_mc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_stb, data_stb, data_we, io_stb, io_we;
  logic [15:0] inst_addr, data_addr, data_wdata, io_addr, io_wdata, mem_rdata;
  logic        man_ack, auto_ack;

  logic [15:0] rr_inst_data, rr_data_data, rr_io_data, rr_mem_addr, rr_mem_wdata;
  logic        rr_inst_ack, rr_data_ack, rr_io_ack, rr_mem_stb, rr_mem_we, rr_err, rr_mem_ack;
  logic [2:0]  rr_grant;
  logic [15:0] fx_inst_data, fx_data_data, fx_io_data, fx_mem_addr, fx_mem_wdata;
  logic        fx_inst_ack, fx_data_ack, fx_io_ack, fx_mem_stb, fx_mem_we, fx_err, fx_mem_ack;
  logic [2:0]  fx_grant;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rr_mem_ack = auto_ack ? rr_mem_stb : man_ack;
  assign fx_mem_ack = auto_ack ? fx_mem_stb : man_ack;

  mc_mem_arbiter #(.AW(16), .DW(16), .PRIO_MODE(0), .TIMEOUT_CYC(8)) u_rr (
    .sys_clk(clk), .sys_rst(rst_n),
    .cpu_inst_stb_i(inst_stb), .cpu_inst_addr_i(inst_addr),
    .cpu_inst_data_o(rr_inst_data), .cpu_inst_ack_o(rr_inst_ack),
    .cpu_data_stb_i(data_stb), .cpu_data_we_i(data_we), .cpu_data_addr_i(data_addr),
    .cpu_data_data_i(data_wdata), .cpu_data_data_o(rr_data_data), .cpu_data_ack_o(rr_data_ack),
    .io_stb_i(io_stb), .io_we_i(io_we), .io_addr_i(io_addr), .io_data_i(io_wdata),
    .io_data_o(rr_io_data), .io_ack_o(rr_io_ack),
    .mem_stb_o(rr_mem_stb), .mem_we_o(rr_mem_we), .mem_addr_o(rr_mem_addr),
    .mem_data_o(rr_mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(rr_mem_ack),
    .grant_o(rr_grant), .arb_err_o(rr_err)
  );

  mc_mem_arbiter #(.AW(16), .DW(16), .PRIO_MODE(1), .TIMEOUT_CYC(8)) u_fx (
    .sys_clk(clk), .sys_rst(rst_n),
    .cpu_inst_stb_i(inst_stb), .cpu_inst_addr_i(inst_addr),
    .cpu_inst_data_o(fx_inst_data), .cpu_inst_ack_o(fx_inst_ack),
    .cpu_data_stb_i(data_stb), .cpu_data_we_i(data_we), .cpu_data_addr_i(data_addr),
    .cpu_data_data_i(data_wdata), .cpu_data_data_o(fx_data_data), .cpu_data_ack_o(fx_data_ack),
    .io_stb_i(io_stb), .io_we_i(io_we), .io_addr_i(io_addr), .io_data_i(io_wdata),
    .io_data_o(fx_io_data), .io_ack_o(fx_io_ack),
    .mem_stb_o(fx_mem_stb), .mem_we_o(fx_mem_we), .mem_addr_o(fx_mem_addr),
    .mem_data_o(fx_mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(fx_mem_ack),
    .grant_o(fx_grant), .arb_err_o(fx_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    inst_stb = 0; data_stb = 0; data_we = 0; io_stb = 0; io_we = 0;
    inst_addr = '0; data_addr = '0; data_wdata = '0; io_addr = '0; io_wdata = '0;
    mem_rdata = '0; man_ack = 0; auto_ack = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 0;
    tick();
    n_cmp++;
    if ({rr_mem_stb, rr_mem_we, rr_grant, rr_inst_ack, rr_data_ack, rr_io_ack, rr_err} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 0", {rr_mem_stb, rr_mem_we, rr_grant, rr_inst_ack, rr_data_ack, rr_io_ack, rr_err});
    end
    n_cmp++;
    if ({rr_mem_addr, rr_mem_wdata, rr_inst_data, rr_data_data, rr_io_data} !== 80'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", {rr_mem_addr, rr_mem_wdata, rr_inst_data, rr_data_data, rr_io_data});
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_inst_read;
    int nstb = 0;
    inst_stb = 1; inst_addr = 16'h0010; mem_rdata = 16'h1234;
    tick();
    n_cmp++;
    if ({rr_mem_addr, rr_mem_we, rr_grant} !== {16'h0010, 1'b0, 3'b001}) begin
      n_err++;
      $display("FAIL inst_busy: got addr=%h we=%b grant=%b want 0010/0/001", rr_mem_addr, rr_mem_we, rr_grant);
    end
    for (int i = 0; i < 3; i++) begin
      if (rr_mem_stb) nstb++;
      if (i == 2) man_ack = 1;
      else tick();
    end
    tick();
    man_ack = 0;
    n_cmp++;
    if (nstb !== 3) begin
      n_err++;
      $display("FAIL inst_stb_len: got %0d want 3", nstb);
    end
    n_cmp++;
    if ({rr_mem_stb, rr_inst_ack, rr_inst_data} !== {1'b0, 1'b1, 16'h1234}) begin
      n_err++;
      $display("FAIL inst_resp: got stb=%b ack=%b data=%h want 0/1/1234", rr_mem_stb, rr_inst_ack, rr_inst_data);
    end
    inst_stb = 0;
    tick();
    n_cmp++;
    if ({rr_inst_ack, rr_grant, rr_inst_data} !== {1'b0, 3'b000, 16'h1234}) begin
      n_err++;
      $display("FAIL inst_after: got ack=%b grant=%b data=%h want 0/000/1234", rr_inst_ack, rr_grant, rr_inst_data);
    end
    man_ack = 1;
    tick();
    man_ack = 0;
    n_cmp++;
    if ({rr_mem_stb, rr_inst_ack, rr_data_ack, rr_io_ack} !== 4'b0) begin
      n_err++;
      $display("FAIL stray_ack: got %b want 0000", {rr_mem_stb, rr_inst_ack, rr_data_ack, rr_io_ack});
    end
  endtask

  task automatic test_data_write;
    int nack = 0;
    auto_ack = 1;
    data_stb = 1; data_we = 0; data_addr = 16'h0200; mem_rdata = 16'h7777;
    tick(); tick();
    n_cmp++;
    if ({rr_data_ack, rr_data_data} !== {1'b1, 16'h7777}) begin
      n_err++;
      $display("FAIL data_read: got ack=%b data=%h want 1/7777", rr_data_ack, rr_data_data);
    end
    data_stb = 0;
    tick();
    data_stb = 1; data_we = 1; data_wdata = 16'hBEEF;
    tick();
    n_cmp++;
    if ({rr_mem_stb, rr_mem_we, rr_mem_addr, rr_mem_wdata, rr_grant} !== {1'b1, 1'b1, 16'h0200, 16'hBEEF, 3'b010}) begin
      n_err++;
      $display("FAIL data_busy: got stb=%b we=%b addr=%h wd=%h grant=%b want 1/1/0200/BEEF/010",
               rr_mem_stb, rr_mem_we, rr_mem_addr, rr_mem_wdata, rr_grant);
    end
    tick();
    if (rr_data_ack) nack++;
    n_cmp++;
    if (rr_data_data !== 16'h0000) begin
      n_err++;
      $display("FAIL data_wr_rdata: got %h want 0000", rr_data_data);
    end
    data_stb = 0; data_we = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rr_data_ack) nack++;
    end
    n_cmp++;
    if (nack !== 1) begin
      n_err++;
      $display("FAIL data_ack_cnt: got %0d want 1", nack);
    end
    auto_ack = 0;
  endtask

  task automatic run_all_three(output logic [2:0] rr_seq [6], output logic [2:0] fx_seq [6],
                               output int rr_cnt [3], output int fx_cnt [3]);
    int rn = 0;
    int fn = 0;
    for (int i = 0; i < 6; i++) begin rr_seq[i] = '0; fx_seq[i] = '0; end
    for (int i = 0; i < 3; i++) begin rr_cnt[i] = 0; fx_cnt[i] = 0; end
    do_reset();
    auto_ack = 1; mem_rdata = 16'h5A5A;
    inst_stb = 1; data_stb = 1; io_stb = 1;
    inst_addr = 16'h0100; data_addr = 16'h0200; io_addr = 16'h0300;
    for (int c = 0; c < 18; c++) begin
      tick();
      if (rr_mem_stb && rn < 6) begin rr_seq[rn] = rr_grant; rn++; end
      if (fx_mem_stb && fn < 6) begin fx_seq[fn] = fx_grant; fn++; end
      if (rr_inst_ack) rr_cnt[0]++;
      if (rr_data_ack) rr_cnt[1]++;
      if (rr_io_ack)   rr_cnt[2]++;
      if (fx_inst_ack) fx_cnt[0]++;
      if (fx_data_ack) fx_cnt[1]++;
      if (fx_io_ack)   fx_cnt[2]++;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_round_robin;
    logic [2:0] rs [6];
    logic [2:0] fs [6];
    int rc [3];
    int fc [3];
    logic [2:0] exp_seq [6];
    exp_seq = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    run_all_three(rs, fs, rc, fc);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (rs[i] !== exp_seq[i]) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: got %b want %b", i, rs[i], exp_seq[i]);
      end
    end
    n_cmp++;
    if ({rc[0], rc[1], rc[2]} !== {32'd2, 32'd2, 32'd2}) begin
      n_err++;
      $display("FAIL rr_ack_cnt: got inst=%0d data=%0d io=%0d want 2/2/2", rc[0], rc[1], rc[2]);
    end
    n_cmp++;
    if (rr_io_data !== 16'h5A5A) begin
      n_err++;
      $display("FAIL rr_io_data: got %h want 5A5A", rr_io_data);
    end
  endtask

  task automatic test_fixed_prio;
    logic [2:0] rs [6];
    logic [2:0] fs [6];
    int rc [3];
    int fc [3];
    int bad = 0;
    run_all_three(rs, fs, rc, fc);
    for (int i = 0; i < 6; i++) if (fs[i] !== 3'b010) bad++;
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL fx_grant: got %0d non-data grants want 0", bad);
    end
    n_cmp++;
    if ({fc[0], fc[1], fc[2]} !== {32'd0, 32'd6, 32'd0}) begin
      n_err++;
      $display("FAIL fx_ack_cnt: got inst=%0d data=%0d io=%0d want 0/6/0", fc[0], fc[1], fc[2]);
    end
  endtask

  task automatic test_reset_busy;
    do_reset();
    io_stb = 1; io_addr = 16'h0033;
    tick();
    n_cmp++;
    if ({rr_mem_stb, rr_grant} !== {1'b1, 3'b100}) begin
      n_err++;
      $display("FAIL rst_pre: got stb=%b grant=%b want 1/100", rr_mem_stb, rr_grant);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({rr_mem_stb, rr_grant} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_async: got stb=%b grant=%b want 0/000", rr_mem_stb, rr_grant);
    end
    tick();
    n_cmp++;
    if ({rr_io_ack, rr_mem_stb} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_noack: got ack=%b stb=%b want 0/0", rr_io_ack, rr_mem_stb);
    end
    rst_n = 1; auto_ack = 1; mem_rdata = 16'h4242;
    tick();
    n_cmp++;
    if ({rr_mem_stb, rr_mem_addr} !== {1'b1, 16'h0033}) begin
      n_err++;
      $display("FAIL rst_reissue: got stb=%b addr=%h want 1/0033", rr_mem_stb, rr_mem_addr);
    end
    tick();
    n_cmp++;
    if ({rr_io_ack, rr_io_data} !== {1'b1, 16'h4242}) begin
      n_err++;
      $display("FAIL rst_serve: got ack=%b data=%h want 1/4242", rr_io_ack, rr_io_data);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout;
    int nstb = 0;
    int nev = 0;
    do_reset();
    io_stb = 1; io_addr = 16'h0044;
`ifdef MC_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rr_mem_stb) nstb++;
      if (rr_io_ack || rr_err) nev++;
    end
    tick();
    n_cmp++;
    if ({nstb, nev} !== {32'd8, 32'd0}) begin
      n_err++;
      $display("FAIL tmo_busy: got stb_cycles=%0d early_events=%0d want 8/0", nstb, nev);
    end
    n_cmp++;
    if ({rr_io_ack, rr_err, rr_mem_stb, rr_io_data} !== {1'b1, 1'b1, 1'b0, 16'hDEAD}) begin
      n_err++;
      $display("FAIL tmo_resp: got ack=%b err=%b stb=%b data=%h want 1/1/0/DEAD",
               rr_io_ack, rr_err, rr_mem_stb, rr_io_data);
    end
    io_stb = 0;
    tick();
    n_cmp++;
    if ({rr_io_ack, rr_err, rr_mem_stb, rr_grant} !== 6'b0) begin
      n_err++;
      $display("FAIL tmo_idle: got ack=%b err=%b stb=%b grant=%b want 0", rr_io_ack, rr_err, rr_mem_stb, rr_grant);
    end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rr_mem_stb) nstb++;
      if (rr_io_ack || rr_err) nev++;
    end
    n_cmp++;
    if ({nstb, nev} !== {32'd20, 32'd0}) begin
      n_err++;
      $display("FAIL no_tmo: got stb_cycles=%0d events=%0d want 20/0", nstb, nev);
    end
    do_reset();
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_inst_read();
    test_data_write();
    test_round_robin();
    test_fixed_prio();
    test_reset_busy();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
